// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache between the CPU
// load/store path and block-organised data memory.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | serve hits; a missing request stalls and picks the next step
// WRITEBACK | push the dirty victim line to memory (MEM_WRITE high)
// FETCH     | pull the requested block from memory (MEM_READ high)
module dcache_controller #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int NUM_BLOCKS  = 8,
  parameter int BLOCK_BYTES = 4
) (
  input  logic                                    CLK,
  input  logic                                    RESET,
  input  logic                                    READ,
  input  logic                                    WRITE,
  input  logic [ADDR_W-1:0]                       ADDRESS,
  input  logic [DATA_W-1:0]                       WRITEDATA,
  output logic [DATA_W-1:0]                       READDATA,
  output logic                                    BUSYWAIT,
  output logic                                    MEM_READ,
  output logic                                    MEM_WRITE,
  output logic [ADDR_W-$clog2(BLOCK_BYTES)-1:0]   MEM_ADDRESS,
  output logic [BLOCK_BYTES*DATA_W-1:0]           MEM_WRITEDATA,
  input  logic [BLOCK_BYTES*DATA_W-1:0]           MEM_READDATA,
  input  logic                                    MEM_BUSYWAIT
);

  localparam int IDX_W  = $clog2(NUM_BLOCKS);
  localparam int OFF_W  = $clog2(BLOCK_BYTES);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int LINE_W = BLOCK_BYTES * DATA_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [NUM_BLOCKS-1:0] valid;
  logic [NUM_BLOCKS-1:0] dirty;
  logic [TAG_W-1:0]      tag_mem  [NUM_BLOCKS];
  logic [LINE_W-1:0]     data_mem [NUM_BLOCKS];

  logic [TAG_W-1:0]  addr_tag;
  logic [IDX_W-1:0]  addr_idx;
  logic [OFF_W-1:0]  addr_off;
  logic [LINE_W-1:0] line_sel;
  logic              hit;
  logic              req;
  logic              store_hit;
  logic              fetch_done;

  assign addr_tag = ADDRESS[ADDR_W-1 -: TAG_W];
  assign addr_idx = ADDRESS[OFF_W +: IDX_W];
  assign addr_off = ADDRESS[OFF_W-1:0];
  assign line_sel = data_mem[addr_idx];

  // READ and WRITE together count as a store, so WRITE alone decides the kind
  assign req        = READ | WRITE;
  assign hit        = valid[addr_idx] && (tag_mem[addr_idx] == addr_tag);
  assign store_hit  = (state == IDLE) && WRITE && hit;
  assign fetch_done = (state == FETCH) && !MEM_BUSYWAIT;

  // Byte select of the indexed line; only meaningful to the CPU on a read hit
  always_comb begin
    READDATA = line_sel[32'(addr_off) * DATA_W +: DATA_W];
  end

  // State register; reset drops any transfer in flight immediately
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and output decode; strobes come straight from the registered state
  always_comb begin
    state_nxt     = state;
    BUSYWAIT      = 1'b0;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = '0;
    MEM_WRITEDATA = '0;
    case (state)
      IDLE: begin
        if (req && !hit) begin
          BUSYWAIT = 1'b1;
          if (valid[addr_idx] && dirty[addr_idx]) begin
            state_nxt = WRITEBACK;
          end else begin
            state_nxt = FETCH;
          end
        end
      end
      WRITEBACK: begin
        BUSYWAIT      = 1'b1;
        MEM_WRITE     = 1'b1;
        MEM_ADDRESS   = {tag_mem[addr_idx], addr_idx};
        MEM_WRITEDATA = line_sel;
        if (!MEM_BUSYWAIT) begin
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        BUSYWAIT    = 1'b1;
        MEM_READ    = 1'b1;
        MEM_ADDRESS = {addr_tag, addr_idx};
        if (!MEM_BUSYWAIT) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Line status bits; a fill marks the line valid only at its completing edge
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      valid <= '0;
      dirty <= '0;
    end else if (fetch_done) begin
      valid[addr_idx] <= 1'b1;
      dirty[addr_idx] <= 1'b0;
    end else if (store_hit) begin
      dirty[addr_idx] <= 1'b1;
    end
  end

  // Tag and data storage; cleared on reset so READDATA starts at zero
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < NUM_BLOCKS; i++) begin
        tag_mem[i]  <= '0;
        data_mem[i] <= '0;
      end
    end else if (fetch_done) begin
      tag_mem[addr_idx]  <= addr_tag;
      data_mem[addr_idx] <= MEM_READDATA;
    end else if (store_hit) begin
      data_mem[addr_idx][32'(addr_off) * DATA_W +: DATA_W] <= WRITEDATA;
    end
  end

endmodule

// File: doc/dcache_controller.md
# dcache_controller

Direct-mapped, write-back, write-allocate data cache that serves the CPU's data-memory requests. The control unit drives READ and WRITE. This block answers on the CPU side with READDATA and BUSYWAIT. On the memory side it issues 32-bit block transfers to data memory over a MEM_READ/MEM_WRITE/MEM_BUSYWAIT handshake. It sits between the datapath (ALU result as address, register file as write data and load destination) and the block-organised data memory.

## Interface
Parameters:
- ADDR_W, 8, CPU byte-address width.
- DATA_W, 8, CPU word width.
- NUM_BLOCKS, 8, cache lines; index width is log2(NUM_BLOCKS) = 3.
- BLOCK_BYTES, 4, bytes per line; offset width is 2, tag width is ADDR_W-5 = 3.

Ports:
- CLK  in  1  single clock; all state updates on its rising edge.
- RESET  in  1  asynchronous, active-low reset.
- READ  in  1  CPU load request (level, held until BUSYWAIT low).
- WRITE  in  1  CPU store request (level, held until BUSYWAIT low).
- ADDRESS  in  8  byte address: tag[7:5], index[4:2], offset[1:0].
- WRITEDATA  in  8  store data.
- READDATA  out  8  load data.
- BUSYWAIT  out  1  CPU stall.
- MEM_READ  out  1  block fetch strobe.
- MEM_WRITE  out  1  block writeback strobe.
- MEM_ADDRESS  out  6  block address {tag,index}.
- MEM_WRITEDATA  out  32  victim block, byte 0 in [7:0].
- MEM_READDATA  in  32  fetched block, byte 0 in [7:0].
- MEM_BUSYWAIT  in  1  memory busy; a transfer completes on the rising edge where the strobe is high and MEM_BUSYWAIT is low.

## Operation
- Per line: valid bit, dirty bit, 3-bit tag, 32-bit data. Reset clears every valid and dirty bit. Tag and data contents are don't-care after reset.
- hit = valid[index] & (tag[index] == ADDRESS[7:5]). This is combinational.
- If READ and WRITE are both high, the request is treated as a store.
- FSM states: IDLE, WRITEBACK, FETCH.
- IDLE, no request: BUSYWAIT=0 and both memory strobes are 0.
- IDLE, read hit: READDATA = the selected byte of the line (combinational), BUSYWAIT=0.
- IDLE, write hit: BUSYWAIT=0. On the next rising edge the byte is written and dirty[index] is set.
- IDLE, miss: BUSYWAIT=1. At the next rising edge the FSM goes to WRITEBACK if valid&dirty, otherwise to FETCH.
- WRITEBACK: MEM_WRITE=1, MEM_ADDRESS={stored tag, index}, MEM_WRITEDATA = line data. On completion the FSM goes to FETCH.
- FETCH: MEM_READ=1, MEM_ADDRESS={ADDRESS[7:5], index}. On completion, at that edge, the line is loaded from MEM_READDATA, the tag is updated, valid=1, dirty=0, and the FSM returns to IDLE.
- After returning to IDLE the held request is evaluated again as a hit: a read returns its data in that cycle, a write is applied at the following edge.
- BUSYWAIT=1 in every state other than IDLE. In IDLE it is 1 whenever a request misses.
- READDATA outside a read hit: holds the combinational byte select. It has no meaning to the CPU.

## Timing
- Reset values: BUSYWAIT=0, MEM_READ=0, MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITEDATA=0, READDATA=0 (all lines invalid), state IDLE.
- Hit latency: 0 stall cycles. Store data commits at the first rising edge after the request is presented.
- Clean miss with a memory busy time of M cycles: 1 (IDLE→FETCH) + (M+1) in FETCH + 1 hit cycle.
- Dirty miss adds M+1 cycles in WRITEBACK.
- Memory strobes are registered-state decodes: glitch-free and stable for the whole transfer. MEM_ADDRESS and MEM_WRITEDATA are stable while their strobe is high.
- MEM_WRITE falls on the same edge MEM_READ rises; the strobes are never high together.
- The CPU keeps READ, WRITE, ADDRESS and WRITEDATA stable while BUSYWAIT=1. Changes during that time are undefined.
- RESET low mid-transfer: strobes drop immediately (asynchronously), state goes to IDLE, and all lines are invalidated. A partially fetched line is never marked valid.

## Test plan
- Reset, then READ at 0x00 with memory block 0 = 0x44332211 and MEM_BUSYWAIT high for 5 cycles → BUSYWAIT high, MEM_READ high with MEM_ADDRESS=0x00 for 6 cycles. After the fill, READDATA=0x11 and BUSYWAIT low.
- Same line then READ 0x03 → READDATA=0x44 with no stall and no memory strobe.
- WRITE 0x03=0xAB (hit) → no stall; then READ 0x03 returns 0xAB, and the dirty bit is set.
- WRITE 0x23=0x5A (same index, tag 1) → MEM_WRITE with MEM_ADDRESS=0x00 and MEM_WRITEDATA=0xAB332211. Then MEM_READ with MEM_ADDRESS=0x08. Then the write is applied and line 0 holds tag 1, dirty.
- RESET pulsed low during FETCH → MEM_READ drops the same cycle and BUSYWAIT=0. A subsequent READ 0x00 misses again.
- READ and WRITE both high at 0x04 with WRITEDATA=0x77 → handled as a store; a later READ 0x04 returns 0x77.
